// File: rtl/i2s_multi_tx_pkg.sv
// Shared constants for the multi-lane I2S transmitter: mode encodings and
// the frame-counter width helper.
package i2s_multi_tx_pkg;

  localparam int SCK_MODE_TIED   = 0;  // DAC derives its own serial clock
  localparam int SCK_MODE_BITCLK = 1;  // sck toggles once per bit slot

  localparam int UND_MODE_ZERO   = 0;  // underrun frame carries a zero word
  localparam int UND_MODE_REPEAT = 1;  // underrun frame repeats the last word

  // One frame = two halves of SAMPLE_W slots, each slot 2^bit_cyc_log2 clocks.
  function automatic int frame_w(input int sample_w, input int bit_cyc_log2);
    return 1 + $clog2(sample_w) + bit_cyc_log2;
  endfunction

endpackage

// File: rtl/i2s_multi_tx_lane.sv
// One stereo output lane: one-entry holding buffer, the word pair being
// shifted out, underrun tracking and the serial data mux.
module i2s_multi_tx_lane
  import i2s_multi_tx_pkg::*;
#(
  parameter int SAMPLE_W      = 16,
  parameter int UNDERRUN_MODE = UND_MODE_ZERO
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic                        lrck,
  input  logic [$clog2(SAMPLE_W)-1:0] slot,
  input  logic [SAMPLE_W-1:0]         s_left,
  input  logic [SAMPLE_W-1:0]         s_right,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        mute,
  input  logic                        clr_underrun,
  output logic                        underrun,
  output logic                        sdin
);

  localparam int SW_LOG2 = $clog2(SAMPLE_W);

  logic                hold_full;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] left_w, right_w;
  logic                rlsb;
  logic                accept;
  logic [SW_LOG2-1:0]  idx;
  logic                sdin_bit;

  assign s_ready = !hold_full;
  assign accept  = s_valid && !hold_full;

  // An accept can only coincide with a load when the buffer was already
  // empty, so accept taking precedence over the load-drain is exact.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;

      if (load && !hold_full) underrun <= 1'b1;
      else if (clr_underrun)  underrun <= 1'b0;
    end
  end

  // NOTE: the payload is deliberately left without reset; hold_full says
  // when it is meaningful, so resetting it would only cost reset routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l <= s_left;
      hold_r <= s_right;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_w  <= '0;
      right_w <= '0;
      rlsb    <= 1'b0;
    end else if (!en) begin
      left_w  <= '0;
      right_w <= '0;
      rlsb    <= 1'b0;
    end else if (load) begin
      rlsb <= right_w[0];
      if (mute) begin
        left_w  <= '0;
        right_w <= '0;
      end else if (hold_full) begin
        left_w  <= hold_l;
        right_w <= hold_r;
      end else if (UNDERRUN_MODE == UND_MODE_ZERO) begin
        left_w  <= '0;
        right_w <= '0;
      end
    end
  end

  // One-slot I2S delay: slot k of a half carries bit SAMPLE_W-k, and slot 0
  // carries the LSB of the word that just finished.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a variable
    // unassigned, which would otherwise infer a latch.
    sdin_bit = 1'b0;
    idx      = SW_LOG2'(SAMPLE_W - int'(slot));
    if (slot == '0) sdin_bit = lrck ? left_w[0] : rlsb;
    else            sdin_bit = lrck ? right_w[idx] : left_w[idx];
  end

  assign sdin = en & sdin_bit;

endmodule

// File: rtl/i2s_multi_tx.sv
// N-lane I2S-style transmitter: shared frame counter and derived clocks,
// one i2s_multi_tx_lane per DAC.
module i2s_multi_tx
  import i2s_multi_tx_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int SAMPLE_W      = 16,
  parameter int BIT_CYC_LOG2  = 4,
  parameter int MCLK_DIV_LOG2 = 2,
  parameter int SCK_MODE      = SCK_MODE_TIED,
  parameter int UNDERRUN_MODE = UND_MODE_ZERO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_left,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_right,
  input  logic [NUM_CH-1:0]          s_valid,
  output logic [NUM_CH-1:0]          s_ready,
  input  logic [NUM_CH-1:0]          mute,
  input  logic [NUM_CH-1:0]          clr_underrun,
  output logic [NUM_CH-1:0]          underrun,
  output logic [NUM_CH-1:0]          audio_mclk,
  output logic [NUM_CH-1:0]          audio_lrck,
  output logic [NUM_CH-1:0]          audio_sck,
  output logic [NUM_CH-1:0]          audio_sdin
);

  localparam int F       = frame_w(SAMPLE_W, BIT_CYC_LOG2);
  localparam int SW_LOG2 = $clog2(SAMPLE_W);

  logic [F-1:0]       fc;
  logic               load;
  logic               lrck;
  logic               sck;
  logic [SW_LOG2-1:0] slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      fc <= '0;
    else if (!en) fc <= '0;
    else          fc <= fc + F'(1);
  end

  assign load = en && (&fc);
  assign lrck = fc[F-1];
  assign slot = fc[F-2:BIT_CYC_LOG2];

  if (SCK_MODE == SCK_MODE_BITCLK) begin : g_sck_bit
    assign sck = fc[BIT_CYC_LOG2-1];
  end else begin : g_sck_tied
    assign sck = 1'b1;
  end

  assign audio_mclk = {NUM_CH{fc[MCLK_DIV_LOG2-1]}};
  assign audio_lrck = {NUM_CH{lrck}};
  assign audio_sck  = {NUM_CH{sck}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    i2s_multi_tx_lane #(
      .SAMPLE_W      (SAMPLE_W),
      .UNDERRUN_MODE (UNDERRUN_MODE)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .load         (load),
      .lrck         (lrck),
      .slot         (slot),
      .s_left       (s_left[i*SAMPLE_W +: SAMPLE_W]),
      .s_right      (s_right[i*SAMPLE_W +: SAMPLE_W]),
      .s_valid      (s_valid[i]),
      .s_ready      (s_ready[i]),
      .mute         (mute[i]),
      .clr_underrun (clr_underrun[i]),
      .underrun     (underrun[i]),
      .sdin         (audio_sdin[i])
    );
  end

endmodule

// File: tb/tb_i2s_multi_tx.sv
// Scoreboard bench: stimulus queues expected serial frames per lane, a
// monitor deserialises sdin and compares each completed frame.
module tb_i2s_multi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [47:0] s_left  = '0;
  logic [47:0] s_right = '0;
  logic [2:0]  s_valid = '0;
  logic [2:0]  mute    = '0;
  logic [2:0]  clr     = '0;

  logic [2:0] ready_a, und_a, mclk_a, lrck_a, sck_a, sdin_a;
  logic [2:0] ready_b, und_b, mclk_b, lrck_b, sck_b, sdin_b;

  always #5 clk = ~clk;

  i2s_multi_tx #(
    .NUM_CH(3), .SAMPLE_W(16), .BIT_CYC_LOG2(4), .MCLK_DIV_LOG2(2),
    .SCK_MODE(0), .UNDERRUN_MODE(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(ready_a), .mute(mute), .clr_underrun(clr),
    .underrun(und_a), .audio_mclk(mclk_a), .audio_lrck(lrck_a),
    .audio_sck(sck_a), .audio_sdin(sdin_a)
  );

  i2s_multi_tx #(
    .NUM_CH(3), .SAMPLE_W(16), .BIT_CYC_LOG2(4), .MCLK_DIV_LOG2(2),
    .SCK_MODE(1), .UNDERRUN_MODE(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(ready_b), .mute(mute), .clr_underrun(clr),
    .underrun(und_b), .audio_mclk(mclk_b), .audio_lrck(lrck_b),
    .audio_sck(sck_b), .audio_sdin(sdin_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame timing; frame_cnt also advances when a frame is aborted
  // so a restarted frame never reuses the id of the aborted one.
  logic [8:0] tb_fc = '0;
  int         frame_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (tb_fc != 0) frame_cnt <= frame_cnt + 1;
      tb_fc <= '0;
    end else if (!en) begin
      if (tb_fc != 0) frame_cnt <= frame_cnt + 1;
      tb_fc <= '0;
    end else begin
      if (tb_fc == 9'd511) frame_cnt <= frame_cnt + 1;
      tb_fc <= tb_fc + 9'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("mclk_a", mclk_a, {3{tb_fc[1]}});
      check("mclk_b", mclk_b, {3{tb_fc[1]}});
      check("lrck_a", lrck_a, {3{tb_fc[8]}});
      check("lrck_b", lrck_b, {3{tb_fc[8]}});
      check("sck_a",  sck_a,  3'b111);
      check("sck_b",  sck_b,  {3{tb_fc[3]}});
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a0, a1, b0, b1;
  } exp_t;

  exp_t q[$];

  function automatic void push_exp(input int id, input logic [31:0] a0, a1, b0, b1);
    exp_t e;
    e.id = id; e.a0 = a0; e.a1 = a1; e.b0 = b0; e.b1 = b1;
    q.push_back(e);
  endfunction

  // Wire order of one frame: previous right LSB, left MSB..LSB, right MSB..bit1.
  function automatic logic [31:0] wf(input logic p, input logic [15:0] l, input logic [15:0] r);
    return {p, l, r[15:1]};
  endfunction

  logic [31:0] sh_a0, sh_a1, sh_b0, sh_b1;
  int          nbits = 0;

  always @(negedge clk) begin
    if (!rst && en && tb_fc[3:0] == 4'd8) begin
      if (tb_fc[8:4] == 5'd0) nbits = 0;
      sh_a0 = {sh_a0[30:0], sdin_a[0]};
      sh_a1 = {sh_a1[30:0], sdin_a[1]};
      sh_b0 = {sh_b0[30:0], sdin_b[0]};
      sh_b1 = {sh_b1[30:0], sdin_b[1]};
      nbits++;
      if (tb_fc[8:4] == 5'd31 && nbits == 32) begin
        while (q.size() > 0 && q[0].id < frame_cnt) begin
          check("missed_frame_id", 64'(q[0].id), 64'(frame_cnt));
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].id == frame_cnt) begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("frame%0d_a_lane0", e.id), sh_a0, e.a0);
          check($sformatf("frame%0d_a_lane1", e.id), sh_a1, e.a1);
          check($sformatf("frame%0d_b_lane0", e.id), sh_b0, e.b0);
          check($sformatf("frame%0d_b_lane1", e.id), sh_b1, e.b1);
        end
      end
    end
  end

  task automatic wait_at(input int f, input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        $display("FAIL wait_at: frame %0d fc %0d never reached", f, c);
        $fatal(1, "bench timeout");
      end
    end while (!(frame_cnt == f && int'(tb_fc) == c));
  endtask

  task automatic offer(input logic [2:0] lanes, input logic [15:0] l0, r0, l1, r1);
    s_left[15:0]   = l0;  s_right[15:0]  = r0;
    s_left[31:16]  = l1;  s_right[31:16] = r1;
    s_valid = lanes;
    @(negedge clk);
    s_valid = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mclk_a", mclk_a, 3'b000);
    check("rst_lrck_a", lrck_a, 3'b000);
    check("rst_sdin_a", sdin_a, 3'b000);
    check("rst_sck_a",  sck_a,  3'b111);
    check("rst_sck_b",  sck_b,  3'b000);
    check("rst_ready_a", ready_a, 3'b111);
    check("rst_und_a",  und_a,  3'b000);

    push_exp(0, 32'h0, 32'h0, 32'h0, 32'h0);
    push_exp(1, wf(1'b0, 16'hA5C3, 16'h0F0F), wf(1'b0, 16'h1234, 16'h8001),
                wf(1'b0, 16'hA5C3, 16'h0F0F), wf(1'b0, 16'h1234, 16'h8001));
    rst = 1'b0;

    // Frame 0: both lanes get their first pair.
    wait_at(0, 100);
    check("ready_before_push", ready_a[1:0], 2'b11);
    offer(3'b011, 16'hA5C3, 16'h0F0F, 16'h1234, 16'h8001);
    check("ready_after_push_a", ready_a[1:0], 2'b00);
    check("ready_after_push_b", ready_b[1:0], 2'b00);

    wait_at(1, 0);
    check("und_frame1_a", und_a, 3'b100);
    check("und_frame1_b", und_b, 3'b100);

    // Frame 1: lane0 back-to-back with s_valid held; lane1 left to underrun.
    push_exp(2, wf(1'b1, 16'h00FF, 16'h8000), 32'h8000_0000,
                wf(1'b1, 16'h00FF, 16'h8000), wf(1'b1, 16'h1234, 16'h8001));
    push_exp(3, wf(1'b0, 16'h7E81, 16'h0003), 32'h0,
                wf(1'b0, 16'h7E81, 16'h0003), 32'h8000_0000);
    wait_at(1, 100);
    s_left[15:0] = 16'h00FF; s_right[15:0] = 16'h8000; s_valid[0] = 1'b1;
    @(negedge clk);
    check("b2b_ready_low", ready_a[0], 1'b0);
    wait_at(1, 511);
    check("b2b_ready_low_at_load", ready_a[0], 1'b0);
    wait_at(2, 0);
    check("b2b_ready_high_after_load_a", ready_a[0], 1'b1);
    check("b2b_ready_high_after_load_b", ready_b[0], 1'b1);
    s_left[15:0] = 16'h7E81; s_right[15:0] = 16'h0003;
    @(negedge clk);
    check("b2b_ready_low_again", ready_a[0], 1'b0);
    s_valid[0] = 1'b0;
    check("und_frame2_a", und_a, 3'b110);
    check("und_frame2_b", und_b, 3'b110);

    // Frame 2: clear lane1 underrun, then a muted pair on lane1.
    wait_at(2, 50);
    clr = 3'b010;
    @(negedge clk);
    clr = 3'b000;
    check("clr_und_a", und_a, 3'b100);
    check("clr_und_b", und_b, 3'b100);
    wait_at(2, 100);
    mute = 3'b010;
    offer(3'b010, 16'h0000, 16'h0000, 16'hCAFE, 16'hBEEF);
    check("mute_push_ready", ready_a[1], 1'b0);

    push_exp(4, 32'h8000_0000, 32'h0, wf(1'b1, 16'h7E81, 16'h0003), 32'h0);
    wait_at(3, 1);
    check("mute_no_underrun", und_a, 3'b100);
    check("mute_hold_consumed", ready_a, 3'b111);
    mute = 3'b000;

    // Frame 3 sends no new pair: both lanes underrun into frame 4.
    wait_at(4, 1);
    check("und_frame4_a", und_a, 3'b111);
    check("und_frame4_b", und_b, 3'b111);
    wait_at(4, 50);
    clr = 3'b011;
    @(negedge clk);
    clr = 3'b000;
    check("clr_und_both", und_a, 3'b100);
    wait_at(4, 100);
    offer(3'b011, 16'h3C5A, 16'h1111, 16'h5555, 16'hAAAA);

    // Frame 5 is aborted by en=0 with a pair waiting in the holding buffer.
    wait_at(5, 100);
    offer(3'b011, 16'h9669, 16'h4242, 16'h0F00, 16'h0002);
    wait_at(5, 300);
    en = 1'b0;
    @(negedge clk);
    check("en0_sdin_a", sdin_a, 3'b000);
    check("en0_sdin_b", sdin_b, 3'b000);
    check("en0_lrck",   lrck_a, 3'b000);
    check("en0_hold_kept", ready_a[1:0], 2'b00);
    repeat (20) @(negedge clk);
    check("en0_sdin_late", sdin_a, 3'b000);
    push_exp(6, 32'h0, 32'h0, 32'h0, 32'h0);
    push_exp(7, wf(1'b0, 16'h9669, 16'h4242), wf(1'b0, 16'h0F00, 16'h0002),
                wf(1'b0, 16'h9669, 16'h4242), wf(1'b0, 16'h0F00, 16'h0002));
    en = 1'b1;

    wait_at(7, 1);
    check("und_frame7", und_a, 3'b100);
    wait_at(8, 1);
    check("und_frame8", und_a, 3'b111);

    // Asynchronous reset mid-frame.
    wait_at(8, 100);
    rst = 1'b1;
    #1;
    check("midrst_mclk", mclk_a, 3'b000);
    check("midrst_lrck", lrck_a, 3'b000);
    check("midrst_sdin_a", sdin_a, 3'b000);
    check("midrst_sdin_b", sdin_b, 3'b000);
    check("midrst_sck_a", sck_a, 3'b111);
    check("midrst_sck_b", sck_b, 3'b000);
    check("midrst_ready", ready_a, 3'b111);
    check("midrst_und_a", und_a, 3'b000);
    check("midrst_und_b", und_b, 3'b000);
    push_exp(9, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_at(10, 5);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
